// File: rtl/jtkcpu_stkbus_pkg.sv
// Shared constants for the KONAMI-2 stack bus responder.
// Register mask bit positions follow the push/pull sequencer encoding.
package jtkcpu_stkbus_pkg;

    localparam int PSH_PC = 7;
    localparam int PSH_US = 6;
    localparam int PSH_Y  = 5;
    localparam int PSH_X  = 4;
    localparam int PSH_DP = 3;
    localparam int PSH_B  = 2;
    localparam int PSH_A  = 1;
    localparam int PSH_CC = 0;
    localparam int CC_E   = 7;

    typedef enum logic {
        DIR_LSB = 1'b0,
        DIR_MSB = 1'b1
    } prio_dir_e;

    // PC, U/S, Y and X occupy the upper nibble of the mask
    function automatic logic is_wide(input logic [7:0] onehot);
        return |onehot[7:4];
    endfunction

endpackage

// File: rtl/jtkcpu_stkbus_prienc8.sv
// 8-bit priority encoder with one-hot grant.
// DIR_MSB grants the highest request, DIR_LSB the lowest.
module jtkcpu_prienc8
    import jtkcpu_stkbus_pkg::*;
(
    input  prio_dir_e  i_dir,
    input  logic [7:0] i_req,
    output logic [7:0] o_gnt
);

    logic [7:0] w_hi;
    logic [7:0] w_lo;

    always_comb begin
        w_hi = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_req[i]) w_hi = 8'd1 << i;
        end
    end

    always_comb begin
        w_lo = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_req[i]) w_lo = 8'd1 << i;
        end
    end

    assign o_gnt = (i_dir == DIR_MSB) ? w_hi : w_lo;

endmodule

// File: rtl/jtkcpu_stkbus.sv
// Stack bus responder for the KONAMI-2 push/pull sequencer.
// Walks one byte per cen cycle and tracks a shadow stack pointer.
module jtkcpu_stkbus
    import jtkcpu_stkbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  psh_sel,
    input  logic        hi_lon,
    input  logic        us_sel,
    input  logic        dec_us,
    input  logic        pul_en,
    input  logic [7:0]  cc,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  dp,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] u,
    input  logic [15:0] s,
    input  logic [15:0] pc,
    input  logic [7:0]  din,
    output logic [7:0]  psh_bit,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        rd,
    output logic        pul_load,
    output logic [7:0]  pul_dst,
    output logic [15:0] pul_data,
    output logic        sp_we,
    output logic        sp_us,
    output logic [15:0] sp_data
);

    logic [15:0] r_ptr;
    logic        r_active;
    logic [7:0]  r_hold;
    logic        r_pul_load;
    logic [7:0]  r_pul_dst;
    logic [15:0] r_pul_data;
    logic        r_sp_we;
    logic        r_sp_us;

    prio_dir_e   w_dir;
    logic [7:0]  w_gnt;
    logic        w_busy;
    logic        w_go;
    logic        w_wide;
    logic        w_first;
    logic        w_last;
    logic [15:0] w_cur;
    logic [15:0] w_dec;
    logic [15:0] w_inc;
    logic [15:0] w_reg16;
    logic [7:0]  w_reg8;
    logic [7:0]  w_byte;

    assign w_dir = dec_us ? DIR_MSB : DIR_LSB;

    jtkcpu_prienc8 u_enc (
        .i_dir (w_dir),
        .i_req (psh_sel),
        .o_gnt (w_gnt)
    );

    assign w_busy  = |psh_sel;
    assign w_go    = w_busy & pul_en;
    assign w_wide  = is_wide(w_gnt);
    assign w_first = ~r_active;

    // the first step of a sequence reloads from the live S/U value
    assign w_cur = w_first ? (us_sel ? u : s) : r_ptr;
    assign w_dec = w_cur - 16'd1;
    assign w_inc = w_cur + 16'd1;

    assign w_last = ((psh_sel & ~w_gnt) == 8'd0) & (~w_wide | ~hi_lon);

    always_comb begin
        w_reg16 = 16'd0;
        unique case (1'b1)
            w_gnt[PSH_PC]: w_reg16 = pc;
            w_gnt[PSH_US]: w_reg16 = us_sel ? s : u;
            w_gnt[PSH_Y]:  w_reg16 = y;
            w_gnt[PSH_X]:  w_reg16 = x;
            default:       w_reg16 = 16'd0;
        endcase
    end

    always_comb begin
        w_reg8 = 8'd0;
        unique case (1'b1)
            w_gnt[PSH_DP]: w_reg8 = dp;
            w_gnt[PSH_B]:  w_reg8 = b;
            w_gnt[PSH_A]:  w_reg8 = a;
            w_gnt[PSH_CC]: w_reg8 = cc;
            default:       w_reg8 = 8'd0;
        endcase
    end

    // low byte goes out first so it lands at the higher address
    assign w_byte = w_wide ? (hi_lon ? w_reg16[7:0] : w_reg16[15:8])
                           : w_reg8;

    assign psh_bit = rst ? 8'd0 : w_gnt;

    always_comb begin
        addr = 16'd0;
        dout = 8'd0;
        if (!rst && w_go) begin
            addr = dec_us ? w_dec : w_cur;
            dout = dec_us ? w_byte : 8'd0;
        end
    end

    assign we       = ~rst & cen & w_go & dec_us;
    assign rd       = ~rst & cen & w_go & ~dec_us;
    assign pul_load = cen & r_pul_load;
    assign sp_we    = cen & r_sp_we;
    assign pul_dst  = r_pul_dst;
    assign pul_data = r_pul_data;
    assign sp_us    = r_sp_us;
    assign sp_data  = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 16'd0;
            r_active <= 1'b0;
            r_sp_we  <= 1'b0;
            r_sp_us  <= 1'b0;
        end else if (cen) begin
            r_sp_we <= 1'b0;
            if (!w_busy) begin
                r_active <= 1'b0;
            end else if (pul_en) begin
                r_active <= ~w_last;
                r_ptr    <= dec_us ? w_dec : w_inc;
                if (w_last) begin
                    r_sp_we <= 1'b1;
                    r_sp_us <= us_sel;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= 8'd0;
            r_pul_load <= 1'b0;
            r_pul_dst  <= 8'd0;
            r_pul_data <= 16'd0;
        end else if (cen) begin
            r_pul_load <= 1'b0;
            if (w_go && !dec_us) begin
                if (w_wide && hi_lon) begin
                    r_hold <= din;
                end else begin
                    r_pul_load <= 1'b1;
                    r_pul_dst  <= w_gnt;
                    r_pul_data <= w_wide ? {r_hold, din} : {8'h00, din};
                end
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_stkbus.sv
// Bench for jtkcpu_stkbus: single-step vector table plus
// multi-cycle push/pull sequences driven by a small sequencer model.
module tb_jtkcpu_stkbus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [7:0]  psh_sel = 8'd0;
    logic        hi_lon = 1'b0;
    logic        us_sel = 1'b0;
    logic        dec_us = 1'b0;
    logic        pul_en = 1'b0;
    logic [7:0]  cc = 8'hC1, a = 8'hA1, b = 8'hB1, dp = 8'hD1;
    logic [15:0] x = 16'h1122, y = 16'h3344, u = 16'h5566;
    logic [15:0] s = 16'h7788, pc = 16'h99AA;
    logic [7:0]  din;
    logic [7:0]  psh_bit;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we, rd, pul_load, sp_we, sp_us;
    logic [7:0]  pul_dst;
    logic [15:0] pul_data, sp_data;

    logic [7:0]  mem [0:65535];
    logic [23:0] wq[$];
    logic [23:0] pq[$];
    logic [23:0] spq[$];
    int          both_n = 0;

    int total = 0;
    int bad = 0;

    jtkcpu_stkbus dut (
        .clk(clk), .rst(rst), .cen(cen), .psh_sel(psh_sel),
        .hi_lon(hi_lon), .us_sel(us_sel), .dec_us(dec_us),
        .pul_en(pul_en), .cc(cc), .a(a), .b(b), .dp(dp),
        .x(x), .y(y), .u(u), .s(s), .pc(pc), .din(din),
        .psh_bit(psh_bit), .addr(addr), .dout(dout), .we(we),
        .rd(rd), .pul_load(pul_load), .pul_dst(pul_dst),
        .pul_data(pul_data), .sp_we(sp_we), .sp_us(sp_us),
        .sp_data(sp_data)
    );

    always #5 clk = ~clk;

    assign din = mem[addr];

    always @(posedge clk) begin
        if (we) wq.push_back({addr, dout});
    end

    always @(negedge clk) begin
        #2;
        if (pul_load) pq.push_back({pul_dst, pul_data});
        if (sp_we) spq.push_back({7'd0, sp_us, sp_data});
        if (pul_load && sp_we) both_n++;
    end

    typedef struct {
        logic [7:0]  sel;
        logic        dec, us, hl, en, ce;
        logic [7:0]  eb;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ew, er;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp_q(input string nm, input logic [23:0] got[$],
                         input int base, input logic [23:0] exp[$]);
        chk({nm, "_n"}, got.size() - base, exp.size());
        foreach (exp[i]) begin
            chk(nm, (base + i < got.size()) ? {8'd0, got[base+i]}
                                            : 32'hFFFF_FFFF, {8'd0, exp[i]});
        end
    endtask

    function automatic logic [7:0] hi_bit(input logic [7:0] m);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) if (m[i]) r = 8'd1 << i;
        return r;
    endfunction

    function automatic logic [7:0] lo_bit(input logic [7:0] m);
        return m & (~m + 8'd1);
    endfunction

    task automatic run_seq(input logic [7:0] mask, input logic push,
                           input logic us, input logic tog,
                           input int stop_at);
        logic [7:0] rem, eb;
        logic       hl;
        int         n, guard;
        rem = mask; hl = 1'b1; n = 0; guard = 0;
        while (rem != 8'd0 && guard < 100) begin
            guard++;
            @(negedge clk); #1;
            cen = tog ? ~cen : 1'b1;
            psh_sel = rem; dec_us = push; us_sel = us; pul_en = 1'b1;
            eb = push ? hi_bit(rem) : lo_bit(rem);
            hi_lon = (|eb[7:4]) ? hl : 1'b0;
            #1 chk("psh_bit", {24'd0, psh_bit}, {24'd0, eb});
            @(posedge clk);
            if (cen) begin
                n++;
                if ((|eb[7:4]) && hl) hl = 1'b0;
                else begin rem &= ~eb; hl = 1'b1; end
            end
            if (stop_at != 0 && n == stop_at) break;
        end
        chk("seq_bound", {31'd0, guard < 100}, 32'd1);
        if (stop_at == 0) begin
            @(negedge clk); #1;
            psh_sel = 8'd0; cen = 1'b1; pul_en = 1'b0;
        end
    endtask

    int wb, pb, sb, bb;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0FFE] = 8'hAA; mem[16'h0FFF] = 8'hBB;
        mem[16'h8000] = 8'h12; mem[16'h8001] = 8'h34;
        mem[16'hFFFF] = 8'h5A;

        tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 16'h7787, 8'hAA, 1'b1, 1'b0};
        tbl[2]  = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 16'h7787, 8'h99, 1'b1, 1'b0};
        tbl[3]  = '{8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 16'h7788, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 16'h7787, 8'hB1, 1'b1, 1'b0};
        tbl[5]  = '{8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 16'h7787, 8'h66, 1'b1, 1'b0};
        tbl[6]  = '{8'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 16'h5565, 8'h77, 1'b1, 1'b0};
        tbl[7]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 16'h5566, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 16'h7787, 8'hD1, 1'b1, 1'b0};
        tbl[9]  = '{8'h30, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 16'h7787, 8'h44, 1'b1, 1'b0};
        tbl[10] = '{8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 16'h7788, 8'h00, 1'b0, 1'b1};
        tbl[11] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 16'h7787, 8'hAA, 1'b0, 1'b0};
        tbl[13] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'h7787, 8'hC1, 1'b1, 1'b0};
        tbl[14] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 16'h5565, 8'h11, 1'b1, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_psh_bit", {24'd0, psh_bit}, 32'd0);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_strobes", {28'd0, we, rd, pul_load, sp_we}, 32'd0);
        chk("rst_sp_data", {16'd0, sp_data}, 32'd0);
        chk("rst_pul", {8'd0, pul_dst, pul_data}, 32'd0);
        chk("rst_sp_us", {31'd0, sp_us}, 32'd0);
        #1 rst = 1'b1;

        // single-step combinational view from a fresh state
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0;
            psh_sel = tbl[i].sel; dec_us = tbl[i].dec; us_sel = tbl[i].us;
            hi_lon = tbl[i].hl; pul_en = tbl[i].en; cen = tbl[i].ce;
            #1;
            chk($sformatf("v%0d_bit", i), {24'd0, psh_bit}, {24'd0, tbl[i].eb});
            chk($sformatf("v%0d_addr", i), {16'd0, addr}, {16'd0, tbl[i].ea});
            chk($sformatf("v%0d_dout", i), {24'd0, dout}, {24'd0, tbl[i].ed});
            chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, tbl[i].ew});
            chk($sformatf("v%0d_rd", i), {31'd0, rd}, {31'd0, tbl[i].er});
            #1 rst = 1'b1; psh_sel = 8'd0; cen = 1'b1; pul_en = 1'b0;
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        // push PC, then a new sequence right after sp_we
        wb = wq.size(); sb = spq.size();
        s = 16'h1000; pc = 16'h1234;
        run_seq(8'h80, 1'b1, 1'b0, 1'b0, 0);
        s = 16'h0FFE;
        run_seq(8'h01, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("push_pc_wr", wq, wb, '{24'h0FFF34, 24'h0FFE12, 24'h0FFDC1});
        cmp_q("push_pc_sp", spq, sb, '{24'h000FFE, 24'h000FFD});

        // pull A,B
        pb = pq.size(); sb = spq.size(); bb = both_n;
        s = 16'h0FFE;
        run_seq(8'h06, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("pull_ab", pq, pb, '{24'h0200AA, 24'h0400BB});
        cmp_q("pull_ab_sp", spq, sb, '{24'h001000});
        chk("pull_ab_same_cyc", both_n - bb, 32'd1);

        // push the other stack pointer (U while on S)
        wb = wq.size(); sb = spq.size();
        u = 16'hBEEF; s = 16'h2000;
        run_seq(8'h40, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("push_u_wr", wq, wb, '{24'h1FFFEF, 24'h1FFEBE});
        cmp_q("push_u_sp", spq, sb, '{24'h001FFE});

        // push everything on U starting at 0000
        wb = wq.size(); sb = spq.size();
        u = 16'h0000; s = 16'h5678; pc = 16'h1234;
        run_seq(8'hFF, 1'b1, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("push_all_wr", wq, wb, '{
            24'hFFFF34, 24'hFFFE12, 24'hFFFD78, 24'hFFFC56,
            24'hFFFB44, 24'hFFFA33, 24'hFFF922, 24'hFFF811,
            24'hFFF7D1, 24'hFFF6B1, 24'hFFF5A1, 24'hFFF4C1});
        cmp_q("push_all_sp", spq, sb, '{24'h01FFF4});

        // pull X
        pb = pq.size(); sb = spq.size();
        s = 16'h8000;
        run_seq(8'h10, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("pull_x", pq, pb, '{24'h101234});
        cmp_q("pull_x_sp", spq, sb, '{24'h008002});

        // pull CC at FFFF wraps to 0000
        pb = pq.size(); sb = spq.size();
        s = 16'hFFFF;
        run_seq(8'h01, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        cmp_q("pull_wrap", pq, pb, '{24'h01005A});
        cmp_q("pull_wrap_sp", spq, sb, '{24'h000000});

        // reset in the middle of a full push
        wb = wq.size(); sb = spq.size();
        s = 16'h3000;
        run_seq(8'hFF, 1'b1, 1'b0, 1'b0, 3);
        #2 rst = 1'b1; #1;
        chk("mid_rst_bit", {24'd0, psh_bit}, 32'd0);
        chk("mid_rst_addr", {16'd0, addr}, 32'd0);
        chk("mid_rst_dout", {24'd0, dout}, 32'd0);
        chk("mid_rst_strb", {28'd0, we, rd, pul_load, sp_we}, 32'd0);
        chk("mid_rst_sp", {16'd0, sp_data}, 32'd0);
        psh_sel = 8'd0; pul_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("mid_rst_nwr", wq.size() - wb, 32'd3);
        chk("mid_rst_nosp", spq.size() - sb, 32'd0);

        // cen toggling: one step per enabled cycle
        wb = wq.size(); sb = spq.size();
        s = 16'h4000; pc = 16'hABCD;
        run_seq(8'h80, 1'b1, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);
        cmp_q("cen_tog_wr", wq, wb, '{24'h3FFFCD, 24'h3FFEAB});
        cmp_q("cen_tog_sp", spq, sb, '{24'h003FFE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
